// File: rtl/refetch_recovery_sequencer.sv
// -----------------------------------------------------------------------------
// refetch_recovery_sequencer
//
// Collects refetch requests from several pipeline stages and keeps the single
// oldest one. Age is measured against the active-list head, which wraps. When
// the recorded op reaches the commit head, the block walks the pipeline phase
// through COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT. It drives the front-end
// clear/stall controls and publishes the refetch PC.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   reqValid      per-requester request strobe (index 0 wins exact age ties)
//   reqType       3-bit refetch type per requester
//   reqAlPtr      active-list index of each requesting op
//   reqPc         PC of each requesting op
//   reqTarget     correct branch target (used only by BRANCH_TARGET)
//   alHeadPtr     current active-list head
//   commitValid   the head op commits this cycle
//   csrTarget     trap vector, captured when recovery starts
//   phase         0 COMMIT, 1 RECOVER_0, 2 RECOVER_1
//   frontClear    clear fetch-to-dispatch pipeline registers
//   frontStall    stall rename/dispatch
//   refetchValid  one-cycle redirect pulse for fetch
//   refetchPc     redirect address (holds its value between recoveries)
//   pendingValid  a recovery is recorded and waiting for its op to commit
// -----------------------------------------------------------------------------
module refetch_recovery_sequencer #(
  parameter int NUM_REQ         = 3,
  parameter int AL_IDX_W        = 6,
  parameter int ADDR_W          = 32,
  parameter int RECOVER1_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           reqValid,
  input  logic [NUM_REQ*3-1:0]         reqType,
  input  logic [NUM_REQ*AL_IDX_W-1:0]  reqAlPtr,
  input  logic [NUM_REQ*ADDR_W-1:0]    reqPc,
  input  logic [NUM_REQ*ADDR_W-1:0]    reqTarget,
  input  logic [AL_IDX_W-1:0]          alHeadPtr,
  input  logic                         commitValid,
  input  logic [ADDR_W-1:0]            csrTarget,
  output logic [1:0]                   phase,
  output logic                         frontClear,
  output logic                         frontStall,
  output logic                         refetchValid,
  output logic [ADDR_W-1:0]            refetchPc,
  output logic                         pendingValid
);

  typedef enum logic [1:0] {
    PH_COMMIT    = 2'd0,
    PH_RECOVER_0 = 2'd1,
    PH_RECOVER_1 = 2'd2
  } phase_t;

  typedef enum logic [2:0] {
    RT_THIS_PC               = 3'd0,
    RT_NEXT_PC               = 3'd1,
    RT_STORE_NEXT_PC         = 3'd2,
    RT_BRANCH_TARGET         = 3'd3,
    RT_NEXT_PC_TO_CSR_TARGET = 3'd4,
    RT_THIS_PC_TO_CSR_TARGET = 3'd5
  } refetch_type_t;

  typedef struct packed {
    logic [2:0]          rtype;
    logic [AL_IDX_W-1:0] ptr;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   target;
  } req_t;

  phase_t              state;
  logic [3:0]          cnt;
  logic                pend_valid;
  req_t                pend;

  req_t                win;
  logic                win_valid;
  logic [AL_IDX_W-1:0] win_age;
  logic [AL_IDX_W-1:0] cand_age;
  logic [AL_IDX_W-1:0] pend_age;
  logic                trigger;
  logic                accept;
  logic [ADDR_W-1:0]   refetch_pc_next;

  // Oldest-request select. Strict '<' keeps the lower index on an age tie.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    win_age   = '0;
    cand_age  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular subtraction gives the distance from the head across the wrap.
      cand_age = reqAlPtr[i*AL_IDX_W +: AL_IDX_W] - alHeadPtr;
      if (reqValid[i] && (!win_valid || cand_age < win_age)) begin
        win_valid  = 1'b1;
        win_age    = cand_age;
        win.rtype  = reqType[i*3 +: 3];
        win.ptr    = reqAlPtr[i*AL_IDX_W +: AL_IDX_W];
        win.pc     = reqPc[i*ADDR_W +: ADDR_W];
        win.target = reqTarget[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // The pending entry's age moves as the head advances, so recompute it.
  assign pend_age = pend.ptr - alHeadPtr;

  assign trigger = (state == PH_COMMIT) && pend_valid && commitValid &&
                   (alHeadPtr == pend.ptr);

  // A request arriving alongside the trigger belongs to a younger op that
  // the recovery flushes anyway, so it is not recorded.
  assign accept = (state == PH_COMMIT) && !trigger && win_valid &&
                  (!pend_valid || win_age < pend_age);

  always_comb begin
    refetch_pc_next = pend.pc;
    case (pend.rtype)
      RT_NEXT_PC, RT_STORE_NEXT_PC:                         refetch_pc_next = pend.pc + ADDR_W'(4);
      RT_BRANCH_TARGET:                                     refetch_pc_next = pend.target;
      RT_NEXT_PC_TO_CSR_TARGET, RT_THIS_PC_TO_CSR_TARGET:   refetch_pc_next = csrTarget;
      default:                                              refetch_pc_next = pend.pc;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PH_COMMIT;
      cnt          <= '0;
      pend_valid   <= 1'b0;
      pend         <= '0;
      frontClear   <= 1'b0;
      frontStall   <= 1'b0;
      refetchValid <= 1'b0;
      refetchPc    <= '0;
    end else begin
      case (state)
        PH_COMMIT: begin
          if (trigger) begin
            state        <= PH_RECOVER_0;
            pend_valid   <= 1'b0;
            frontClear   <= 1'b1;
            frontStall   <= 1'b1;
            refetchValid <= 1'b1;
            refetchPc    <= refetch_pc_next;
          end else if (accept) begin
            pend_valid <= 1'b1;
            pend       <= win;
          end
        end
        PH_RECOVER_0: begin
          state        <= PH_RECOVER_1;
          cnt          <= 4'(RECOVER1_CYCLES);
          frontClear   <= 1'b0;
          refetchValid <= 1'b0;
        end
        PH_RECOVER_1: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= PH_COMMIT;
            frontStall <= 1'b0;
          end
        end
        default: begin
          state        <= PH_COMMIT;
          frontClear   <= 1'b0;
          frontStall   <= 1'b0;
          refetchValid <= 1'b0;
        end
      endcase
    end
  end

  assign phase        = state;
  assign pendingValid = pend_valid;

endmodule

// File: tb/tb_refetch_recovery_sequencer.sv
// -----------------------------------------------------------------------------
// tb_refetch_recovery_sequencer
//
// Table-driven bench: each record holds one cycle of inputs and the outputs
// expected just after the following rising edge. Asynchronous reset during
// recovery is exercised by a hand-written sequence at the end.
// -----------------------------------------------------------------------------
module tb_refetch_recovery_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  reqValid = '0;
  logic [8:0]  reqType = '0;
  logic [17:0] reqAlPtr = '0;
  logic [95:0] reqPc = '0;
  logic [95:0] reqTarget = '0;
  logic [5:0]  alHeadPtr = '0;
  logic        commitValid = 1'b0;
  logic [31:0] csrTarget = '0;
  logic [1:0]  phase;
  logic        frontClear;
  logic        frontStall;
  logic        refetchValid;
  logic [31:0] refetchPc;
  logic        pendingValid;

  int checks = 0;
  int failures = 0;

  refetch_recovery_sequencer #(
    .NUM_REQ(3), .AL_IDX_W(6), .ADDR_W(32), .RECOVER1_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqType(reqType), .reqAlPtr(reqAlPtr),
    .reqPc(reqPc), .reqTarget(reqTarget), .alHeadPtr(alHeadPtr),
    .commitValid(commitValid), .csrTarget(csrTarget),
    .phase(phase), .frontClear(frontClear), .frontStall(frontStall),
    .refetchValid(refetchValid), .refetchPc(refetchPc), .pendingValid(pendingValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [8:0]  typ;
    logic [17:0] ptr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [5:0]  head;
    logic        cv;
    logic [31:0] csr;
    logic [1:0]  e_ph;
    logic        e_clr;
    logic        e_stl;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_pv;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // pc and tgt are replicated to every requester slot.
  task automatic add(input logic [2:0] v, input logic [8:0] typ, input logic [17:0] ptr,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic [5:0] head,
                     input logic cv, input logic [1:0] ph, input logic clr, input logic stl,
                     input logic rv, input logic [31:0] epc, input logic pv);
    vec_t r;
    r.v = v; r.typ = typ; r.ptr = ptr; r.pc = pc; r.tgt = tgt;
    r.head = head; r.cv = cv; r.csr = 32'h80;
    r.e_ph = ph; r.e_clr = clr; r.e_stl = stl; r.e_rv = rv; r.e_pc = epc; r.e_pv = pv;
    vq.push_back(r);
  endtask

  task automatic idle(input logic [5:0] head, input logic cv, input logic [1:0] ph,
                      input logic clr, input logic stl, input logic rv,
                      input logic [31:0] epc, input logic pv);
    add(3'b000, 9'd0, 18'd0, 32'h0, 32'h0, head, cv, ph, clr, stl, rv, epc, pv);
  endtask

  // Cycles following a trigger: four RECOVER_1 cycles, then back to COMMIT.
  // With with_req set, a request is driven throughout and must be ignored.
  task automatic tail(input logic [31:0] epc, input logic with_req);
    logic [2:0] v;
    v = with_req ? 3'b001 : 3'b000;
    for (int k = 0; k < 4; k++)
      add(v, 9'd0, 18'd7, 32'h700, 32'h0, 6'd0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, epc, 1'b0);
    add(v, 9'd0, 18'd7, 32'h700, 32'h0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, epc, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t r);
    reqValid    = r.v;
    reqType     = r.typ;
    reqAlPtr    = r.ptr;
    reqPc       = {3{r.pc}};
    reqTarget   = {3{r.tgt}};
    alHeadPtr   = r.head;
    commitValid = r.cv;
    csrTarget   = r.csr;
  endtask

  initial begin
    // ---- reset state (clocks running while reset is held) ----
    repeat (3) @(posedge clk);
    #1;
    check("reset phase", 32'(phase), 32'd0);
    check("reset frontClear", 32'(frontClear), 32'd0);
    check("reset frontStall", 32'(frontStall), 32'd0);
    check("reset refetchValid", 32'(refetchValid), 32'd0);
    check("reset refetchPc", refetchPc, 32'd0);
    check("reset pendingValid", 32'(pendingValid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- 1: single branch-target request, head walks up to it ----
    add(3'b001, 9'd3, 18'd5, 32'h500, 32'h1000, 6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h0, 1);
    for (int h = 0; h < 5; h++) idle(6'(h), 1'b1, 2'd0, 0, 0, 0, 32'h0, 1);
    idle(6'd5, 1'b1, 2'd1, 1, 1, 1, 32'h1000, 0);
    tail(32'h1000, 1'b0);

    // ---- 2a: wrap, head=60: ptr 62 (age 2) beats ptr 2 (age 6) ----
    add(3'b011, {3'd0, 3'd1, 3'd0}, {6'd0, 6'd2, 6'd62}, 32'h300, 32'h0, 6'd60, 1'b0,
        2'd0, 0, 0, 0, 32'h1000, 1);
    idle(6'd62, 1'b1, 2'd1, 1, 1, 1, 32'h300, 0);
    tail(32'h300, 1'b0);

    // ---- 2b: ptr 61 replaces 62; later ptr 63 is dropped ----
    add(3'b001, 9'd0, 18'd62, 32'h300, 32'h0, 6'd60, 1'b0, 2'd0, 0, 0, 0, 32'h300, 1);
    add(3'b001, 9'd1, 18'd61, 32'h300, 32'h0, 6'd60, 1'b0, 2'd0, 0, 0, 0, 32'h300, 1);
    add(3'b100, 9'd0, {6'd63, 12'd0}, 32'h300, 32'h0, 6'd60, 1'b0, 2'd0, 0, 0, 0, 32'h300, 1);
    idle(6'd61, 1'b1, 2'd1, 1, 1, 1, 32'h304, 0);
    tail(32'h304, 1'b0);

    // ---- 3: exact tie, req0 (THIS_PC) beats req2 (NEXT_PC); request in the
    //         trigger cycle and during recovery is discarded ----
    add(3'b101, {3'd1, 3'd0, 3'd0}, {6'd10, 6'd0, 6'd10}, 32'h200, 32'h0, 6'd8, 1'b0,
        2'd0, 0, 0, 0, 32'h304, 1);
    add(3'b010, 9'd0, {6'd0, 6'd11, 6'd0}, 32'h900, 32'h0, 6'd10, 1'b1,
        2'd1, 1, 1, 1, 32'h200, 0);
    tail(32'h200, 1'b1);
    idle(6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h200, 0);

    // ---- 4: PC arithmetic ----
    add(3'b001, 9'd1, 18'd3, 32'hFFFF_FFFC, 32'h0, 6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h200, 1);
    idle(6'd3, 1'b1, 2'd1, 1, 1, 1, 32'h0, 0);
    tail(32'h0, 1'b0);
    add(3'b001, 9'd4, 18'd3, 32'h40, 32'h0, 6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h0, 1);
    idle(6'd3, 1'b1, 2'd1, 1, 1, 1, 32'h80, 0);
    tail(32'h80, 1'b0);
    add(3'b001, 9'd7, 18'd3, 32'h40, 32'h0, 6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h80, 1);
    idle(6'd3, 1'b1, 2'd1, 1, 1, 1, 32'h40, 0);
    tail(32'h40, 1'b0);
    add(3'b001, 9'd2, 18'd3, 32'h10, 32'h0, 6'd0, 1'b0, 2'd0, 0, 0, 0, 32'h40, 1);
    idle(6'd3, 1'b1, 2'd1, 1, 1, 1, 32'h14, 0);
    tail(32'h14, 1'b0);

    foreach (vq[i]) begin
      drive(vq[i]);
      step();
      check($sformatf("v%0d phase", i), 32'(phase), 32'(vq[i].e_ph));
      check($sformatf("v%0d frontClear", i), 32'(frontClear), 32'(vq[i].e_clr));
      check($sformatf("v%0d frontStall", i), 32'(frontStall), 32'(vq[i].e_stl));
      check($sformatf("v%0d refetchValid", i), 32'(refetchValid), 32'(vq[i].e_rv));
      check($sformatf("v%0d refetchPc", i), refetchPc, vq[i].e_pc);
      check($sformatf("v%0d pendingValid", i), 32'(pendingValid), 32'(vq[i].e_pv));
    end

    // ---- 6: asynchronous reset in RECOVER_1 ----
    reqValid = 3'b001; reqType = 9'd3; reqAlPtr = 18'd5;
    reqTarget = {3{32'h1000}}; alHeadPtr = 6'd0; commitValid = 1'b0;
    step();
    reqValid = 3'b000; alHeadPtr = 6'd5; commitValid = 1'b1;
    step();
    commitValid = 1'b0;
    step();
    check("pre-reset phase", 32'(phase), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async phase", 32'(phase), 32'd0);
    check("async frontClear", 32'(frontClear), 32'd0);
    check("async frontStall", 32'(frontStall), 32'd0);
    check("async refetchValid", 32'(refetchValid), 32'd0);
    check("async refetchPc", refetchPc, 32'd0);
    check("async pendingValid", 32'(pendingValid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Head sits on the dropped op's pointer; no recovery may start.
    commitValid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("post-reset c%0d refetchValid", k), 32'(refetchValid), 32'd0);
      check($sformatf("post-reset c%0d phase", k), 32'(phase), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/refetch_recovery_sequencer.md
Name: refetch_recovery_sequencer

Overview:
Collects refetch requests from the integer back end (branch miss), the memory tag-access stage (load/store ordering violations) and the commit stage (traps). It keeps the single oldest pending request, measured by age relative to the active-list head. When that op reaches the commit head, it sequences the pipeline phase through COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT. It drives the stall/clear controls for the front end and publishes the refetch PC.

Parameters:
NUM_REQ, 3, number of refetch requesters; index 0 has highest priority on an exact age tie.
AL_IDX_W, 6, active-list index width; the list has 2^AL_IDX_W entries and wraps around.
ADDR_W, 32, PC width.
RECOVER1_CYCLES, 4, cycles spent in RECOVER_1 (range 1..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
reqValid  in  NUM_REQ  per-requester refetch request.
reqType  in  NUM_REQ*3  RefetchType encoding (0 THIS_PC, 1 NEXT_PC, 2 STORE_NEXT_PC, 3 BRANCH_TARGET, 4 NEXT_PC_TO_CSR_TARGET, 5 THIS_PC_TO_CSR_TARGET).
reqAlPtr  in  NUM_REQ*AL_IDX_W  active-list index of the requesting op.
reqPc  in  NUM_REQ*ADDR_W  PC of the requesting op.
reqTarget  in  NUM_REQ*ADDR_W  correct branch target (used only for type 3).
alHeadPtr  in  AL_IDX_W  current active-list head.
commitValid  in  1  the head op commits this cycle.
csrTarget  in  ADDR_W  trap vector, sampled on the cycle RECOVER_0 is entered.
phase  out  2  0 COMMIT, 1 RECOVER_0, 2 RECOVER_1.
frontClear  out  1  clear fetch-to-dispatch pipeline registers.
frontStall  out  1  stall rename/dispatch.
refetchValid  out  1  one-cycle pulse; redirect fetch to refetchPc.
refetchPc  out  ADDR_W  refetch address.
pendingValid  out  1  a recovery is recorded and waiting.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - phase=COMMIT.
  - All outputs 0.
  - Pending register cleared; counter cleared.
- Age of a pointer is (ptr - alHeadPtr) mod 2^AL_IDX_W. Smaller age is older.
- Selection each cycle:
  - Among valid requests, pick the minimum age.
  - On an exact age tie, the lowest index wins.
  - The winner replaces the pending entry if none is pending, or if the winner's age is strictly less than the pending entry's age (recomputed against the current head). Otherwise the winner is dropped.
- Requests are accepted only in COMMIT. In RECOVER_0 and RECOVER_1 they are ignored.
- Trigger:
  - Condition: in COMMIT with pendingValid=1, commitValid=1 and alHeadPtr==pending ptr.
  - Next cycle: phase=RECOVER_0 and pending is cleared.
  - If a new request arrives in the trigger cycle, it is discarded; its op is younger and will be flushed.
- RECOVER_0 (exactly 1 cycle):
  - frontClear=1, frontStall=1, refetchValid=1.
  - refetchPc by type:
    - 0: pc.
    - 1 and 2: pc+4, modulo 2^ADDR_W.
    - 3: target.
    - 4 and 5: csrTarget.
    - Encodings 6 and 7: treated as THIS_PC.
  - Counter loads RECOVER1_CYCLES. Next cycle: RECOVER_1.
- RECOVER_1:
  - frontStall=1, frontClear=0, refetchValid=0.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, next phase is COMMIT.
- COMMIT: frontClear=0 and frontStall=0.
- refetchPc holds its last value outside RECOVER_0.
- Outputs are registered; phase and the controls change only on a clock edge.
- Reset asserted mid-recovery returns to COMMIT immediately and drops the pending entry.

Test Plan:
1. Single request: head=0, req0 type3 alPtr=5 target=0x1000; hold commitValid while head advances to 5 -> pendingValid until the head is 5; next cycle phase=1, refetchValid=1, refetchPc=0x1000; then 4 cycles of phase=2 with frontStall=1; then phase=0.
2. Age ordering with wrap: head=60 (AL_IDX_W=6); req1 alPtr=2 and req0 alPtr=62 in the same cycle -> alPtr 62 (age 2) is kept. A later request with alPtr=61 replaces it; a later one with alPtr=63 is dropped.
3. Tie: req0 and req2 both alPtr=10, types 0 and 1 with pc 0x200 -> req0 wins; refetchPc=0x200.
4. PC arithmetic: type1 pc=0xFFFFFFFC -> refetchPc=0x00000000. Type4 with csrTarget=0x80 -> 0x80. Type7 pc=0x40 -> 0x40.
5. Requests during recovery: a request asserted in RECOVER_1 -> pendingValid stays 0 after returning to COMMIT.
6. Reset mid-recovery: drop rst_n during RECOVER_1 -> phase=0 and all outputs 0 immediately (asynchronous); no refetchValid after rst_n is released.
